wavetable_voice_mixer: RTL
==========================

Name: wavetable_voice_mixer

Overview:
- Consumer end of the per-voice wavetable address interface.
- On each audio sample tick it latches the 8 per-voice table addresses and the active-voice mask.
- It then reads the shared wavetable BRAM once per voice through a fixed-latency pipeline and sums the active voices into one signed mix sample.
- Sits between the address generator and the audio output / PWM stage.

Parameters:
- ADDR_WIDTH, 8, width of each wavetable address (table depth 2^ADDR_WIDTH).
- SAMPLE_WIDTH, 16, width of each signed two's-complement BRAM sample.
- BRAM_LATENCY, 2, cycles from bram_addr_out to valid bram_data_in (supported range 1..4).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- sample_tick_in  input  1  one-cycle pulse; starts a mix frame.
- addr_in  input  [ADDR_WIDTH-1:0] x8  per-voice table addresses (unpacked [7:0]).
- active_voices_in  input  8  per-voice active mask.
- bram_addr_out  output  ADDR_WIDTH  wavetable read address.
- bram_en_out  output  1  read enable.
- bram_data_in  input  SAMPLE_WIDTH  signed read data, valid BRAM_LATENCY cycles after the address.
- mix_out  output  SAMPLE_WIDTH+3  signed mixed sample.
- mix_valid_out  output  1  one-cycle pulse when mix_out updates.
- voice_count_out  output  4  number of active voices in the last frame (0..8).
- busy_out  output  1  frame in progress.
- overrun_out  output  1  one-cycle pulse when a tick arrives while busy.

Behaviour:
- Reset (async, rst_n_in=0):
  - Outputs: all outputs 0.
  - Internal state: FSM to IDLE, accumulator, latches and pipeline tags cleared.
  - A reset asserted mid-frame aborts the frame; no mix_valid_out follows.
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - On sample_tick_in (cycle T), latch addr_in[0..7] and active_voices_in.
  - Clear the accumulator and voice index, then go to ISSUE.
  - busy_out=1 from T+1.
- ISSUE (cycles T+1..T+8):
  - bram_en_out=1; bram_addr_out = latched addr[k] at cycle T+1+k, k=0..7, in ascending order, every voice.
  - A BRAM_LATENCY-deep shift register carries (valid, active[k]) alongside each read.
  - After k=7, go to DRAIN.
- DRAIN:
  - bram_en_out=0, bram_addr_out holds its last value.
  - The accumulator adds sign-extended bram_data_in whenever the tag is valid and active.
  - Inactive voices contribute 0.
  - Leave when the last tag has been consumed (cycle T+8+BRAM_LATENCY).
- OUTPUT (cycle T+9+BRAM_LATENCY):
  - mix_out <= final sum; voice_count_out <= popcount of latched mask; mix_valid_out=1 for exactly this cycle.
  - busy_out=0 from the next cycle; return to IDLE.
  - Total latency: tick to mix_valid_out = 9+BRAM_LATENCY cycles (11 at default).
- Arithmetic:
  - The accumulator is SAMPLE_WIDTH+3 bits signed; the 8-sample sum cannot overflow, so there is no saturation.
- Boundary conditions:
  - Zero active voices: the full read sequence still runs; mix_out=0, voice_count_out=0, mix_valid_out still pulses.
  - Tick while busy: ignored, the frame continues unchanged, overrun_out pulses once.
  - Tick in the OUTPUT cycle: counts as busy (overrun).
  - Tick the cycle after OUTPUT: accepted.
  - addr_in/active_voices_in changing mid-frame has no effect; only values at tick time are used.
- mix_out and voice_count_out hold between frames.

Optional Feature:
- Macro: MIXER_NORMALIZE_EN.
- When defined, OUTPUT stage applies an arithmetic right shift by active count before registering mix_out:
  - 0-1 voices: shift 0.
  - 2 voices: shift 1.
  - 3-4 voices: shift 2.
  - 5-8 voices: shift 3.
- The shift adds no latency.
- When undefined, mix_out is the raw sum.
- Port list and widths are identical in both builds.

Test Plan:
- Reset then idle: hold rst_n_in=0, release, no tick -> all outputs 0, bram_en_out=0 indefinitely.
- Single voice, BRAM model returns data=addr*4:
  - Stimulus: tick with active=8'b0000_0001, addr[0]=8'h10.
  - Required: bram_addr_out sequence is addr[0..7] on cycles T+1..T+8; mix_out=64; voice_count_out=1; mix_valid_out at exactly T+11.
- All 8 voices, BRAM returns 16'sh7FFF:
  - Raw build: mix_out=262136, voice_count_out=8.
  - MIXER_NORMALIZE_EN build: mix_out=32767.
- Mixed signs: active=8'hA5, voice k returns (k odd ? -1000 : +3000) -> mix_out=3000+3000-1000-1000=4000, voice_count_out=4.
- Overrun: second tick at T+5 -> overrun_out pulses at T+6, single mix_valid_out at T+11 with first-frame values; tick at T+12 is accepted normally.
- Reset mid-frame: rst_n_in low at T+6 -> outputs 0 immediately, no mix_valid_out; next tick after release yields the correct frame.

Source files
------------

// File: rtl/wavetable_voice_mixer.sv
// Per-tick 8-voice wavetable reader and signed mixer over a shared BRAM.
// Define MIXER_NORMALIZE_EN to scale the mix down by the active voice count.
module wavetable_voice_mixer #(
   parameter int ADDR_WIDTH   = 8,
   parameter int SAMPLE_WIDTH = 16,
   parameter int BRAM_LATENCY = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic                           sample_tick_in,
   input  logic [ADDR_WIDTH-1:0]          addr_in [7:0],
   input  logic [7:0]                     active_voices_in,
   output logic [ADDR_WIDTH-1:0]          bram_addr_out,
   output logic                           bram_en_out,
   input  logic [SAMPLE_WIDTH-1:0]        bram_data_in,
   output logic signed [SAMPLE_WIDTH+2:0] mix_out,
   output logic                           mix_valid_out,
   output logic [3:0]                     voice_count_out,
   output logic                           busy_out,
   output logic                           overrun_out
);

   localparam int AW = SAMPLE_WIDTH + 3;
   localparam int L  = BRAM_LATENCY;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUTPUT
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q [7:0];
   logic [7:0]            mask_q;
   logic [2:0]            idx_q;
   logic [L-1:0]          tv_q;
   logic [L-1:0]          ta_q;
   logic [L-1:0]          tl_q;
   logic signed [AW-1:0]  acc_q;
   logic signed [AW-1:0]  acc_d;
   logic signed [AW-1:0]  sum_add;
   logic signed [AW-1:0]  norm;
   logic [3:0]            count;
   logic                  start;
   logic                  last_in;

   assign start   = sample_tick_in && (state_q == IDLE);
   assign last_in = tv_q[L-1] && tl_q[L-1];

   assign bram_en_out   = (state_q == ISSUE);
   assign bram_addr_out = addr_q[idx_q];
   assign busy_out      = (state_q != IDLE);
   assign mix_valid_out = (state_q == OUTPUT);

   always_comb begin
      sum_add = '0;
      if (tv_q[L-1] && ta_q[L-1]) begin
         sum_add = {{3{bram_data_in[SAMPLE_WIDTH-1]}},
                    bram_data_in};
      end
      acc_d = acc_q + sum_add;
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < 8; i++) begin
         count = count + {3'b000, mask_q[i]};
      end
   end

`ifdef MIXER_NORMALIZE_EN
   logic [1:0] shamt;

   always_comb begin
      if (count <= 4'd1) begin
         shamt = 2'd0;
      end else if (count == 4'd2) begin
         shamt = 2'd1;
      end else if (count <= 4'd4) begin
         shamt = 2'd2;
      end else begin
         shamt = 2'd3;
      end
      norm = acc_d >>> shamt;
   end
`else
   assign norm = acc_d;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sample_tick_in) state_d = ISSUE;
         ISSUE:   if (idx_q == 3'd7) state_d = DRAIN;
         DRAIN:   if (last_in) state_d = OUTPUT;
         OUTPUT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q         <= IDLE;
         mask_q          <= '0;
         idx_q           <= '0;
         acc_q           <= '0;
         tv_q            <= '0;
         ta_q            <= '0;
         tl_q            <= '0;
         mix_out         <= '0;
         voice_count_out <= '0;
         overrun_out     <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            addr_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         overrun_out <= sample_tick_in && (state_q != IDLE);
         if (start) begin
            addr_q <= addr_in;
            mask_q <= active_voices_in;
            idx_q  <= '0;
            acc_q  <= '0;
         end else begin
            acc_q <= acc_d;
            if (state_q == ISSUE && idx_q != 3'd7) begin
               idx_q <= idx_q + 3'd1;
            end
         end
         // tag travels with each read so data is matched to its voice
         tv_q[0] <= (state_q == ISSUE);
         ta_q[0] <= mask_q[idx_q];
         tl_q[0] <= (idx_q == 3'd7);
         for (int i = 1; i < L; i++) begin
            tv_q[i] <= tv_q[i-1];
            ta_q[i] <= ta_q[i-1];
            tl_q[i] <= tl_q[i-1];
         end
         if (state_q == DRAIN && last_in) begin
            mix_out         <= norm;
            voice_count_out <= count;
         end
      end
   end

endmodule
